// File: rtl/data_route_pkg.sv
// Shared types for the data_route register slices: slice FSM states and the
// occupancy encoding derived from them.
package data_route_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } slice_state_t;

    // Number of beats held in each state.
    function automatic logic [OCC_W-1:0] state_occ(input slice_state_t s);
        logic [OCC_W-1:0] occ;
        occ = '0;
        case (s)
            EMPTY:   occ = 2'd0;
            BUSY:    occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/backward_reg_slice_if.sv
// AXI-Stream style handshake bundle (tdata/tvalid/tready) used on both sides
// of the register slice.
interface backward_reg_slice_if #(
    parameter int DWIDTH = 32
);
    logic [DWIDTH-1:0] tdata;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/backward_reg_slice.sv
// Full AXI-Stream register slice: two-entry skid buffer so tready, tvalid and
// tdata all leave the slice straight from flops. Sustains one beat per cycle.
module backward_reg_slice
    import data_route_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    backward_reg_slice_if.slave   s_in,
    backward_reg_slice_if.master  m_out,
    output logic [OCC_W-1:0]      occupancy,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    input  logic                  stall_clr
);

    slice_state_t          state_q, state_d;
    logic [DWIDTH-1:0]     main_q, main_d;
    logic [DWIDTH-1:0]     skid_q, skid_d;
    logic                  rdy_q, rdy_d;
    logic                  vld_q, vld_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  acc;
    logic                  pop;

    // Handshake qualifiers only look at our own flops on the driven side.
    assign acc = s_in.tvalid & rdy_q;
    assign pop = vld_q & m_out.tready;

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        rdy_d   = rdy_q;
        vld_d   = vld_q;

        case (state_q)
            EMPTY: begin
                rdy_d = 1'b1;
                vld_d = 1'b0;
                if (acc) begin
                    main_d  = s_in.tdata;
                    vld_d   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (acc && pop) begin
                    main_d = s_in.tdata;
                end else if (acc) begin
                    // Downstream stalled: park the new beat behind main_q.
                    skid_d  = s_in.tdata;
                    rdy_d   = 1'b0;
                    state_d = FULL;
                end else if (pop) begin
                    vld_d   = 1'b0;
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    main_d  = skid_q;
                    rdy_d   = 1'b1;
                    state_d = BUSY;
                end
            end
            default: begin
                rdy_d   = 1'b0;
                vld_d   = 1'b0;
                state_d = EMPTY;
            end
        endcase

        occ_d = state_occ(state_d);
    end

    // NOTE: main_q/skid_q are reset even though they are data, because main_q
    // drives m_out.tdata directly and must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            occ_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values computed above, independent of statement order.
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
            occ_q   <= occ_d;
        end
    end

    // Saturating stall counter; clear has priority over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (stall_clr) begin
            cnt_q <= '0;
        end else if (vld_q && !m_out.tready && !(&cnt_q)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign s_in.tready  = rdy_q;
    assign m_out.tvalid = vld_q;
    assign m_out.tdata  = main_q;
    assign occupancy    = occ_q;
    assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_backward_reg_slice.sv
// Scoreboard bench for backward_reg_slice: accepted beats are queued, a monitor
// pops and compares every output beat and checks hold-while-stalled.
module tb_backward_reg_slice;

    localparam int DW = 32;

    logic clk;
    logic rst_n;
    logic stall_clr;
    logic [1:0]  occ0, occ1;
    logic [15:0] stall0;
    logic [3:0]  stall1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q[$];

    backward_reg_slice_if #(.DWIDTH(DW)) in_if ();
    backward_reg_slice_if #(.DWIDTH(DW)) out_if ();
    backward_reg_slice_if #(.DWIDTH(DW)) in2_if ();
    backward_reg_slice_if #(.DWIDTH(DW)) out2_if ();

    backward_reg_slice #(.DWIDTH(DW), .CNT_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_in      (in_if.slave),
        .m_out     (out_if.master),
        .occupancy (occ0),
        .stall_cnt (stall0),
        .stall_clr (stall_clr)
    );

    // Narrow-counter copy driven in lockstep, used for the saturation check.
    assign in2_if.tdata   = in_if.tdata;
    assign in2_if.tvalid  = in_if.tvalid;
    assign out2_if.tready = out_if.tready;

    backward_reg_slice #(.DWIDTH(DW), .CNT_WIDTH(4)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_in      (in2_if.slave),
        .m_out     (out2_if.master),
        .occupancy (occ1),
        .stall_cnt (stall1),
        .stall_clr (stall_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one beat and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic send(input logic [DW-1:0] d);
        logic accepted;
        accepted = 1'b0;
        in_if.tdata  = d;
        in_if.tvalid = 1'b1;
        for (int c = 0; c < 200 && !accepted; c++) begin
            @(negedge clk);
            accepted = in_if.tready;
            @(posedge clk);
            #1;
        end
        in_if.tvalid = 1'b0;
        check("send_accept", {31'd0, accepted}, 32'd1);
    endtask

    // Monitor: scoreboard push/pop plus stability of a stalled output.
    initial begin
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", {31'd0, out_if.tvalid}, 32'd1);
                    check("hold_data", out_if.tdata, prev_data);
                end
                if (out_if.tvalid && out_if.tready) begin
                    check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) check("beat", out_if.tdata, exp_q.pop_front());
                end
                if (in_if.tvalid && in_if.tready) exp_q.push_back(in_if.tdata);
                prev_stall = out_if.tvalid & ~out_if.tready;
                prev_data  = out_if.tdata;
            end
        end
    end

    initial begin
        int   sent;
        int   cyc;
        logic acc;

        // T1: reset with upstream valid asserted
        rst_n         = 1'b0;
        stall_clr     = 1'b0;
        in_if.tvalid  = 1'b1;
        in_if.tdata   = 32'hdead_beef;
        out_if.tready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_tready", {31'd0, in_if.tready}, 32'd0);
        check("rst_tvalid", {31'd0, out_if.tvalid}, 32'd0);
        check("rst_tdata", out_if.tdata, 32'd0);
        check("rst_occ", {30'd0, occ0}, 32'd0);
        check("rst_stall", {16'd0, stall0}, 32'd0);
        in_if.tvalid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rel_tready_low", {31'd0, in_if.tready}, 32'd0);
        @(posedge clk);
        #1;
        check("rel_tready_high", {31'd0, in_if.tready}, 32'd1);

        // T2: back-to-back streaming, one cycle latency, no bubbles
        out_if.tready = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            send(32'(i));
            check("t2_vld", {31'd0, out_if.tvalid}, 32'd1);
            check("t2_data", out_if.tdata, 32'(i));
            check("t2_occ", {30'd0, occ0}, 32'd1);
        end
        @(posedge clk);
        #1;
        check("t2_drained", {30'd0, occ0}, 32'd0);

        // T3: backpressure fills the skid buffer
        out_if.tready = 1'b0;
        send(32'hA);
        send(32'hB);
        check("t3_tready", {31'd0, in_if.tready}, 32'd0);
        check("t3_occ", {30'd0, occ0}, 32'd2);
        in_if.tdata  = 32'hC;
        in_if.tvalid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("t3_c_held", {31'd0, in_if.tready}, 32'd0);
            check("t3_head", out_if.tdata, 32'hA);
        end
        out_if.tready = 1'b1;
        send(32'hC);
        @(posedge clk);
        #1;
        check("t3_empty_sb", 32'(exp_q.size()), 32'd0);

        // T5: stall counter, clear, and saturation on the 4-bit copy
        out_if.tready = 1'b0;
        stall_clr = 1'b1;
        send(32'h5A);
        stall_clr = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("t5_stall5", {16'd0, stall0}, 32'd5);
        check("t5_stall5_sat", {28'd0, stall1}, 32'd5);
        stall_clr = 1'b1;
        @(posedge clk);
        #1;
        stall_clr = 1'b0;
        check("t5_clr", {16'd0, stall0}, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("t5_stall20", {16'd0, stall0}, 32'd20);
        check("t5_saturate", {28'd0, stall1}, 32'd15);
        out_if.tready = 1'b1;
        @(posedge clk);
        #1;

        // T4: random valid/ready, AXI-legal upstream (valid held until accepted)
        sent = 0;
        cyc  = 0;
        while (sent < 10000 && cyc < 80000) begin
            if (!in_if.tvalid) begin
                in_if.tvalid = 1'($urandom_range(0, 1));
                in_if.tdata  = $urandom;
            end
            out_if.tready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_if.tvalid & in_if.tready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                sent++;
                in_if.tvalid = 1'b0;
            end
        end
        in_if.tvalid = 1'b0;
        check("t4_sent", 32'(sent), 32'd10000);
        out_if.tready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // T6: async reset while FULL discards buffered beats
        out_if.tready = 1'b0;
        send(32'h71);
        send(32'h72);
        check("t6_full", {30'd0, occ0}, 32'd2);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t6_tvalid", {31'd0, out_if.tvalid}, 32'd0);
        check("t6_tready", {31'd0, in_if.tready}, 32'd0);
        check("t6_occ", {30'd0, occ0}, 32'd0);
        check("t6_tdata", out_if.tdata, 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_if.tready = 1'b1;
        send(32'h55);
        check("t6_first", out_if.tdata, 32'h55);
        repeat (2) @(posedge clk);
        #1;
        check("final_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
